instruction_fetch_unit: RTL and testbench

Front end of the pipeline. It holds the PC, issues one-outstanding-request fetches to instruction memory over a req/ack handshake, and buffers returned words in a 2-entry queue. It presents {pc, instruction, valid} to the IF/ID register, whose load enable drives `id_ready`. EX-stage branch redirects flush the queue, and any stale in-flight response is discarded.

---
 rtl/instruction_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Pipeline front end. Holds the fetch PC, runs a single-outstanding req/ack
// handshake to instruction memory and buffers returned words in a 2-entry
// queue that feeds the IF/ID register. A branch redirect flushes the queue
// and, if a request is still in flight, keeps presenting that request until
// its ack arrives so the stale word can be thrown away (KILL state).
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous reset, active low
//   imem_req       out  fetch request, held until imem_ack
//   imem_addr      out  fetch address, stable while imem_req
//   imem_ack       in   one-cycle response strobe (may coincide with req)
//   imem_rdata     in   instruction word, valid with imem_ack
//   redirect       in   branch taken / flush pulse
//   redirect_pc    in   new fetch PC, sampled with redirect
//   id_ready       in   IF/ID load enable; pop when id_valid && id_ready
//   id_valid       out  queue head valid
//   id_instruction out  head instruction, 0 when empty
//   id_pc          out  head PC, 0 when empty
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_KILL  = 1'b1;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        pending_q, pending_d;
  logic [0:0]  state_q, state_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] q_pc_q    [2];
  logic [31:0] q_pc_d    [2];
  logic [31:0] q_instr_q [2];
  logic [31:0] q_instr_d [2];

  logic ack_acc;
  logic push;
  logic pop;

  // Output decode. The request is forced low while reset is held so the
  // memory sees no request until release, independent of any clock edge.
  always_comb begin
    imem_req       = reset && ((state_q == ST_KILL) || pending_q || (count_q != 2'd2));
    imem_addr      = (state_q == ST_KILL) ? kill_addr_q : pc_q;
    id_valid       = (count_q != 2'd0);
    id_pc          = id_valid ? q_pc_q[rd_ptr_q]    : 32'h0;
    id_instruction = id_valid ? q_instr_q[rd_ptr_q] : 32'h0;
  end

  // An ack with no request on the bus is not ours; ignore it.
  always_comb begin
    ack_acc = imem_ack && imem_req;
    push    = (state_q == ST_FETCH) && ack_acc && !redirect;
    pop     = id_valid && id_ready && !redirect;
  end

  // Queue storage and occupancy
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      q_pc_d[i]    = q_pc_q[i];
      q_instr_d[i] = q_instr_q[i];
    end
    if (push) begin
      q_pc_d[wr_ptr_q]    = pc_q;
      q_instr_d[wr_ptr_q] = imem_rdata;
    end

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  // PC / handshake / kill control
  always_comb begin
    pc_d        = pc_q;
    pending_d   = pending_q;
    state_d     = state_q;
    kill_addr_d = kill_addr_q;

    if (redirect) begin
      pc_d = redirect_pc;
      if (state_q == ST_KILL) begin
        // The old request may complete in this very cycle; once it does
        // there is nothing left to discard.
        if (ack_acc) begin
          state_d   = ST_FETCH;
          pending_d = 1'b0;
        end
      end else if (ack_acc) begin
        // Response lands with the redirect: simply drop it.
        pending_d = 1'b0;
      end else if (pending_q || imem_req) begin
        // A request is on the bus and cannot be withdrawn; keep it up at
        // its original address and discard whatever comes back.
        state_d     = ST_KILL;
        pending_d   = 1'b1;
        kill_addr_d = pc_q;
      end
    end else if (state_q == ST_KILL) begin
      if (ack_acc) begin
        state_d   = ST_FETCH;
        pending_d = 1'b0;
      end
    end else begin
      if (ack_acc) begin
        pc_d      = pc_q + 32'd4;
        pending_d = 1'b0;
      end else if (imem_req) begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      pending_q   <= 1'b0;
      state_q     <= ST_FETCH;
      kill_addr_q <= RESET_PC;
      for (int i = 0; i < 2; i++) begin
        q_pc_q[i]    <= 32'h0;
        q_instr_q[i] <= 32'h0;
      end
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      kill_addr_q <= kill_addr_d;
      for (int i = 0; i < 2; i++) begin
        q_pc_q[i]    <= q_pc_d[i];
        q_instr_q[i] <= q_instr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
`timescale 1ns/1ps

module tb_instruction_fetch_unit;

  localparam logic [31:0] K       = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid),
    .id_instruction(id_instruction), .id_pc(id_pc)
  );

  // Second instance for the PC wrap case, with a zero-wait memory tied on
  logic        w_reset_n;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  assign w_ack   = w_req;
  assign w_rdata = w_addr ^ K;

  instruction_fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(w_reset_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0),
    .id_ready(1'b1), .id_valid(w_valid),
    .id_instruction(w_instr), .id_pc(w_pc)
  );

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  // ---------------- reference model: a plain FIFO of fetched words -------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_kill_addr;
  bit          m_pending;
  bit          m_kill;

  function automatic void model_reset();
    mq.delete();
    m_pc        = RST_PC;
    m_kill_addr = RST_PC;
    m_pending   = 1'b0;
    m_kill      = 1'b0;
  endfunction

  function automatic bit model_req();
    return reset_n && (m_kill || m_pending || (mq.size() < 2));
  endfunction

  function automatic void model_check();
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    bit          e_valid;
    e_addr  = m_kill ? m_kill_addr : m_pc;
    e_valid = (mq.size() > 0);
    e_pc    = e_valid ? mq[0].pc  : 32'h0;
    e_ins   = e_valid ? mq[0].ins : 32'h0;
    chk1("m_req",   imem_req, model_req());
    chk ("m_addr",  imem_addr, e_addr);
    chk1("m_valid", id_valid, e_valid);
    chk ("m_pc",    id_pc, e_pc);
    chk ("m_instr", id_instruction, e_ins);
  endfunction

  function automatic void model_advance(bit req_pre);
    bit   ack;
    ent_t e;
    ack = imem_ack && req_pre;
    if (redirect) begin
      mq.delete();
      if (m_kill) begin
        if (ack) begin m_kill = 1'b0; m_pending = 1'b0; end
      end else if (ack) begin
        m_pending = 1'b0;
      end else if (req_pre) begin
        m_kill      = 1'b1;
        m_pending   = 1'b1;
        m_kill_addr = m_pc;
      end
      m_pc = redirect_pc;
    end else if (m_kill) begin
      if (ack) begin m_kill = 1'b0; m_pending = 1'b0; end
    end else begin
      if (mq.size() > 0 && id_ready) void'(mq.pop_front());
      if (ack) begin
        e.pc  = m_pc;
        e.ins = imem_rdata;
        mq.push_back(e);
        m_pc      = m_pc + 32'd4;
        m_pending = 1'b0;
      end else if (req_pre) begin
        m_pending = 1'b1;
      end
    end
  endfunction

  // ---------------- memory: acks after mem_lat wait cycles ---------------------
  int mem_lat  = 0;
  int mem_wait = 0;
  bit rand_lat = 1'b0;

  task automatic mem_drive();
    if (imem_req && mem_wait >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = imem_addr ^ K;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  task automatic mem_advance(bit dut_req);
    if (imem_ack) begin
      mem_wait = 0;
      if (rand_lat) mem_lat = $urandom_range(0, 3);
    end else if (dut_req) begin
      mem_wait++;
    end
  endtask

  // One clock cycle: inputs already set by the caller.
  task automatic cycle();
    bit req_pre;
    bit dut_req;
    mem_drive();
    #1;
    req_pre = model_req();
    dut_req = imem_req;
    model_check();
    if (id_valid && id_ready && !redirect)
      $display("xfer pc=%h instr=%h", id_pc, id_instruction);
    @(posedge clk);
    model_advance(req_pre);
    mem_advance(dut_req);
    #1;
    redirect = 1'b0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk1({tag, "_req"},   imem_req, 1'b0);
    chk ({tag, "_addr"},  imem_addr, RST_PC);
    chk1({tag, "_valid"}, id_valid, 1'b0);
    chk ({tag, "_instr"}, id_instruction, 32'h0);
    chk ({tag, "_pc"},    id_pc, 32'h0);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    imem_ack = 1'b0;
    redirect = 1'b0;
    model_reset();
    mem_wait = 0;
    #1;
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          pre_rst;
    bit          ready;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(bit r, bit rdy, bit rq, logic [31:0] a, bit v, logic [31:0] p);
    vec_t t;
    t.pre_rst = r; t.ready = rdy; t.req = rq; t.addr = a; t.valid = v; t.pc = p;
    return t;
  endfunction

  vec_t tbl[13];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit          found;
    bit          saw_stale;
    logic [31:0] first_pc;

    reset_n     = 1'b0;
    w_reset_n   = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b1;
    model_reset();

    // Zero-wait streaming, then 5 cycles of backpressure from reset
    tbl[0]  = mk(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h108);
    tbl[4]  = mk(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 32'h100);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 32'h108, 1'b1, 32'h100);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h108);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h10C);

    repeat (2) @(posedge clk);
    #1;
    rand_lat = 1'b0;
    mem_lat  = 0;

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].pre_rst) do_reset();
      id_ready = tbl[i].ready;
      $display("vec %0d ready=%0b req=%0b addr=%h valid=%0b pc=%h",
               i, id_ready, imem_req, imem_addr, id_valid, id_pc);
      chk1($sformatf("tbl%0d_req", i),   imem_req, tbl[i].req);
      chk ($sformatf("tbl%0d_addr", i),  imem_addr, tbl[i].addr);
      chk1($sformatf("tbl%0d_valid", i), id_valid, tbl[i].valid);
      chk ($sformatf("tbl%0d_pc", i),    id_pc, tbl[i].pc);
      chk ($sformatf("tbl%0d_instr", i), id_instruction,
           tbl[i].valid ? (tbl[i].pc ^ K) : 32'h0);
      cycle();
    end

    // ---- redirect while a 3-cycle fetch of 0x108 is pending ----
    do_reset();
    mem_lat  = 3;
    id_ready = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req && imem_addr == 32'h108) begin found = 1'b1; break; end
      cycle();
    end
    chk1("pend_seen_req108", found, 1'b1);
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    $display("redirect-while-pending: kill addr=%h", imem_addr);
    chk ("pend_kill_addr", imem_addr, 32'h108);
    chk1("pend_kill_req", imem_req, 1'b1);
    chk1("pend_flush_valid", id_valid, 1'b0);
    found     = 1'b0;
    saw_stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (id_valid && id_pc == 32'h108) saw_stale = 1'b1;
      if (imem_ack) begin found = 1'b1; break; end
    end
    chk1("pend_kill_ack", found, 1'b1);
    chk ("pend_addr_after_ack", imem_addr, 32'h200);
    first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      if (id_valid) begin first_pc = id_pc; break; end
      cycle();
    end
    chk ("pend_first_pc", first_pc, 32'h200);
    chk1("pend_no_stale", saw_stale, 1'b0);

    // ---- redirect coincident with ack for 0x104 ----
    do_reset();
    mem_lat  = 2;
    id_ready = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req && imem_addr == 32'h104 && mem_wait >= mem_lat) begin found = 1'b1; break; end
      cycle();
    end
    chk1("coinc_reach", found, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    cycle();
    $display("redirect-with-ack: next addr=%h", imem_addr);
    chk1("coinc_ack", imem_ack, 1'b1);
    chk ("coinc_addr", imem_addr, 32'h300);
    chk1("coinc_valid", id_valid, 1'b0);
    first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      if (id_valid) begin first_pc = id_pc; break; end
      cycle();
    end
    chk("coinc_first_pc", first_pc, 32'h300);

    // ---- PC wrap on the second instance ----
    chk1("wrap_rst_req", w_req, 1'b0);
    chk ("wrap_rst_addr", w_addr, WRAP_PC);
    w_reset_n = 1'b1;
    #1;
    chk1("wrap_c0_req", w_req, 1'b1);
    chk ("wrap_c0_addr", w_addr, WRAP_PC);
    chk1("wrap_c0_valid", w_valid, 1'b0);
    @(posedge clk); #1;
    $display("wrap: pc=%h instr=%h", w_pc, w_instr);
    chk ("wrap_c1_pc", w_pc, WRAP_PC);
    chk ("wrap_c1_instr", w_instr, WRAP_PC ^ K);
    chk ("wrap_c1_addr", w_addr, 32'h0);
    @(posedge clk); #1;
    $display("wrap: pc=%h instr=%h", w_pc, w_instr);
    chk ("wrap_c2_pc", w_pc, 32'h0);
    chk ("wrap_c2_instr", w_instr, K);
    chk1("wrap_c2_valid", w_valid, 1'b1);

    // ---- mid-operation reset with a full queue ----
    do_reset();
    mem_lat  = 0;
    id_ready = 1'b0;
    repeat (3) cycle();
    chk1("full_before_rst_req", imem_req, 1'b0);
    #2;
    reset_n  = 1'b0;
    imem_ack = 1'b0;
    model_reset();
    mem_wait = 0;
    #1;
    $display("async reset with full queue");
    chk_reset_outputs("async_full");

    // ---- mid-operation reset with a request pending ----
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    mem_lat  = 5;
    id_ready = 1'b1;
    repeat (2) cycle();
    #2;
    reset_n  = 1'b0;
    imem_ack = 1'b0;
    model_reset();
    mem_wait = 0;
    #1;
    $display("async reset with request pending");
    chk_reset_outputs("async_pend");
    // Late ack while held in reset must leave nothing behind
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk1("late_ack_in_rst_valid", id_valid, 1'b0);
    imem_ack = 1'b0;
    reset_n  = 1'b1;
    #1;
    chk1("late_ack_rel_valid", id_valid, 1'b0);
    chk1("late_ack_rel_req", imem_req, 1'b1);
    chk ("late_ack_rel_addr", imem_addr, RST_PC);

    // ---- randomized traffic against the model ----
    rand_lat = 1'b1;
    mem_lat  = $urandom_range(0, 3);
    for (int i = 0; i < 1200; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom & 32'hFFFF_FFFC;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
